// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_pkg;

  // Fetch FSM states; the top keeps its state in a register of this type.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } pc_state_e;

  // Winning redirect after priority resolution (jalr > jal > branch).
  typedef enum logic [1:0] {
    RK_NONE   = 2'd0,
    RK_BRANCH = 2'd1,
    RK_JAL    = 2'd2,
    RK_JALR   = 2'd3
  } redir_kind_e;

  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;
  localparam logic [63:0] DEF_TRAP_VECTOR  = 64'h100;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational target datapath: redirect priority, jalr bit0 clear,
// sequential/auipc adders, next-PC selection and alignment check.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PC_STEP    = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] target_pc_i,
  input  logic            branch_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic            auipc_i,
  input  logic            pend_valid_i,
  input  logic [XLEN-1:0] pend_target_i,
  output redir_kind_e     kind_o,
  output logic [XLEN-1:0] redir_target_o,
  output logic [XLEN-1:0] apply_target_o,
  output logic            apply_misaligned_o,
  output logic [XLEN-1:0] next_pc_o
);

  // Low address bits that must be clear; ALIGN_BITS = 0 yields an empty mask.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] auipc_pc;
  logic            check_align;

  assign seq_pc     = pc_i + XLEN'(PC_STEP);
  assign rel_target = pc_i + imm_i;
  assign jalr_sum   = target_pc_i + imm_i;
  assign auipc_pc   = pc_i + {imm_i[XLEN-13:0], 12'b0};
  assign next_pc_o  = auipc_i ? auipc_pc : seq_pc;

  // Resolve simultaneous redirects by fixed priority and pick the target.
  always_comb begin
    kind_o         = RK_NONE;
    redir_target_o = rel_target;
    if (jalr_i) begin
      kind_o         = RK_JALR;
      redir_target_o = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal_i) begin
      kind_o = RK_JAL;
    end else if (branch_i) begin
      kind_o = RK_BRANCH;
    end
  end

  // Address applied on an accept: live redirect, else buffered, else sequential.
  always_comb begin
    apply_target_o = seq_pc;
    check_align    = 1'b0;
    if (kind_o != RK_NONE) begin
      apply_target_o = redir_target_o;
      check_align    = 1'b1;
    end else if (pend_valid_i) begin
      apply_target_o = pend_target_i;
      check_align    = 1'b1;
    end
    apply_misaligned_o = check_align && ((apply_target_o & ALIGN_MASK) != '0);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter unit: holds the PC, issues fetch requests, buffers one
// redirect while memory back-pressures, traps on misaligned targets and
// counts accepted fetches.
//
// Handshake: a request is accepted when fetch_valid & fetch_ready & !stall;
// while fetch_valid is high and the request is not accepted, endereco holds.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 64,
  parameter int              PC_STEP      = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int              CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             auipc,
  input  logic [XLEN-1:0]  target_pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             fetch_ready,
  input  logic             trap_ack,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  endereco,
  output logic [XLEN-1:0]  next_pc,
  output logic             misaligned,
  output logic [XLEN-1:0]  trap_pc,
  output logic [CNT_W-1:0] fetch_count
);

  pc_state_e        state_q;
  logic             fetch_valid_q;
  logic [XLEN-1:0]  pc_q;
  logic             misaligned_q;
  logic [XLEN-1:0]  trap_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_valid_q;
  logic [XLEN-1:0]  pend_target_q;

  redir_kind_e      kind;
  logic [XLEN-1:0]  redir_target;
  logic [XLEN-1:0]  apply_target;
  logic             apply_misaligned;
  logic             redir_any;
  logic             accept;

  pc_target_calc #(
    .XLEN       (XLEN),
    .PC_STEP    (PC_STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_calc (
    .pc_i               (pc_q),
    .imm_i              (imm),
    .target_pc_i        (target_pc),
    .branch_i           (branch),
    .jal_i              (jal),
    .jalr_i             (jalr),
    .auipc_i            (auipc),
    .pend_valid_i       (pend_valid_q),
    .pend_target_i      (pend_target_q),
    .kind_o             (kind),
    .redir_target_o     (redir_target),
    .apply_target_o     (apply_target),
    .apply_misaligned_o (apply_misaligned),
    .next_pc_o          (next_pc)
  );

  assign redir_any = (kind != RK_NONE);
  assign accept    = fetch_valid_q & fetch_ready & ~stall;
  assign cnt_d     = cnt_q + CNT_W'(1);

  // FSM, PC, pending-redirect buffer, trap capture and fetch counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      fetch_valid_q <= 1'b0;
      pc_q          <= RESET_VECTOR;
      misaligned_q  <= 1'b0;
      trap_pc_q     <= '0;
      cnt_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (!stall) begin
      case (state_q)
        ST_BOOT: begin
          state_q       <= ST_FETCH;
          fetch_valid_q <= 1'b1;
        end
        ST_FETCH: begin
          if (accept) begin
            cnt_q        <= cnt_d;
            pend_valid_q <= 1'b0;
            if (apply_misaligned) begin
              pc_q          <= TRAP_VECTOR;
              trap_pc_q     <= apply_target;
              misaligned_q  <= 1'b1;
              state_q       <= ST_TRAP;
              fetch_valid_q <= 1'b0;
            end else begin
              pc_q <= apply_target;
            end
          end else if (redir_any) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= redir_target;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            state_q       <= ST_FETCH;
            fetch_valid_q <= 1'b1;
            misaligned_q  <= 1'b0;
            pc_q          <= TRAP_VECTOR;
          end
        end
        default: begin
          state_q       <= ST_BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign endereco    = pc_q;
  assign misaligned  = misaligned_q;
  assign trap_pc     = trap_pc_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized traffic, compared each cycle against a behavioural model.
module tb_pc_fetch_unit;

  localparam int              XLEN = 64;
  localparam int              CW   = 32;
  localparam logic [XLEN-1:0] TV   = 64'h100;

  logic            clock;
  logic            reset;
  logic            stall, branch, jal, jalr, auipc, fetch_ready, trap_ack;
  logic [XLEN-1:0] target_pc, imm;
  logic            fetch_valid, misaligned;
  logic [XLEN-1:0] endereco, next_pc, trap_pc;
  logic [CW-1:0]   fetch_count;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural reference state
  logic [XLEN-1:0] m_pc, m_trap_pc, m_pend_t;
  logic            m_boot, m_trap, m_misal, m_pend_v;
  logic [CW-1:0]   m_cnt;

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .PC_STEP      (4),
    .ALIGN_BITS   (2),
    .RESET_VECTOR (64'h0),
    .TRAP_VECTOR  (TV),
    .CNT_W        (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .branch      (branch),
    .jal         (jal),
    .jalr        (jalr),
    .auipc       (auipc),
    .target_pc   (target_pc),
    .imm         (imm),
    .fetch_ready (fetch_ready),
    .trap_ack    (trap_ack),
    .fetch_valid (fetch_valid),
    .endereco    (endereco),
    .next_pc     (next_pc),
    .misaligned  (misaligned),
    .trap_pc     (trap_pc),
    .fetch_count (fetch_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_trap_pc = '0; m_pend_t = '0;
    m_boot = 1'b1; m_trap = 1'b0; m_misal = 1'b0; m_pend_v = 1'b0;
    m_cnt = '0;
  endtask

  // One clock of the reference behaviour, using the currently driven inputs.
  task automatic model_step();
    logic            have_redir, chk;
    logic [XLEN-1:0] tgt, dest;
    if (stall) return;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_trap) begin
      if (trap_ack) begin
        m_trap = 1'b0; m_misal = 1'b0; m_pc = TV;
      end
    end else begin
      have_redir = branch | jal | jalr;
      if (jalr) tgt = (target_pc + imm) & ~64'd1;
      else      tgt = m_pc + imm;
      if (fetch_ready) begin
        m_cnt = m_cnt + 1;
        if (have_redir)    begin dest = tgt;      chk = 1'b1; end
        else if (m_pend_v) begin dest = m_pend_t; chk = 1'b1; end
        else               begin dest = m_pc + 4; chk = 1'b0; end
        m_pend_v = 1'b0;
        if (chk && (dest % 4 != 0)) begin
          m_trap = 1'b1; m_misal = 1'b1; m_trap_pc = dest; m_pc = TV;
        end else begin
          m_pc = dest;
        end
      end else if (have_redir) begin
        m_pend_v = 1'b1; m_pend_t = tgt;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [XLEN-1:0] exp_np;
    exp_np = auipc ? (m_pc + (imm << 12)) : (m_pc + 64'd4);
    check_eq({tag, ".valid"}, 64'(fetch_valid), 64'(!m_boot && !m_trap));
    check_eq({tag, ".pc"},    endereco, m_pc);
    check_eq({tag, ".misal"}, 64'(misaligned), 64'(m_misal));
    check_eq({tag, ".trappc"}, trap_pc, m_trap_pc);
    check_eq({tag, ".cnt"},   64'(fetch_count), 64'(m_cnt));
    check_eq({tag, ".npc"},   next_pc, exp_np);
  endtask

  // Driver: apply inputs just after an edge, check, advance model and clock.
  task automatic cycle(input string tag, input logic st, input logic br, input logic j,
                       input logic jr, input logic au, input logic [XLEN-1:0] tp,
                       input logic [XLEN-1:0] im, input logic rdy, input logic ack);
    stall = st; branch = br; jal = j; jalr = jr; auipc = au;
    target_pc = tp; imm = im; fetch_ready = rdy; trap_ack = ack;
    #3;
    check_outputs(tag);
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag, input logic rdy);
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_eq("rst.pc",    endereco, 64'h0);
    check_eq("rst.valid", 64'(fetch_valid), 64'h0);
    check_eq("rst.misal", 64'(misaligned), 64'h0);
    check_eq("rst.trappc", trap_pc, 64'h0);
    check_eq("rst.cnt",   64'(fetch_count), 64'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int k;
    logic [XLEN-1:0] r_imm, r_tp;
    reset = 1'b1; stall = 0; branch = 0; jal = 0; jalr = 0; auipc = 0;
    target_pc = '0; imm = '0; fetch_ready = 0; trap_ack = 0;
    @(posedge clock);
    #1;

    // Reset and boot: one idle cycle, then 0, 4, 8
    do_reset();
    idle("boot", 1'b1);
    idle("seq0", 1'b1);
    idle("seq4", 1'b1);
    idle("seq8", 1'b1);
    check_eq("plan_cnt3", 64'(fetch_count), 64'd3);
    check_eq("plan_pc12", endereco, 64'd12);

    // Back-pressure with a buffered jal
    do_reset();
    idle("boot", 1'b1);
    idle("a0", 1'b1);
    idle("a4", 1'b1);
    cycle("jal_hold", 0, 0, 1, 0, 0, '0, 64'd32, 1'b0, 0);
    idle("hold1", 1'b0);
    idle("hold2", 1'b0);
    check_eq("plan_hold8", endereco, 64'd8);
    idle("release", 1'b1);
    check_eq("plan_buf40", endereco, 64'd40);

    // Buffered target discarded by a mid-operation reset
    cycle("jal_pend", 0, 0, 1, 0, 0, '0, 64'd64, 1'b0, 0);
    do_reset();
    idle("boot", 1'b1);
    idle("after_rst", 1'b1);
    check_eq("plan_rst_disc", endereco, 64'd4);

    // Priority: jalr wins, bit0 cleared; 'h202 fails 4-byte alignment
    do_reset();
    idle("boot", 1'b1);
    for (int i = 0; i < 4; i++) idle("to16", 1'b1);
    cycle("prio", 0, 1, 1, 1, 0, 64'h201, 64'd2, 1'b1, 0);
    check_eq("plan_prio_tpc", trap_pc, 64'h202);
    idle("trap_wait", 1'b1);
    cycle("ack", 0, 0, 0, 0, 0, '0, '0, 1'b1, 1);

    // Misaligned branch trap and recovery
    do_reset();
    idle("boot", 1'b1);
    cycle("mis_br", 0, 1, 0, 0, 0, '0, 64'd6, 1'b1, 0);
    check_eq("plan_mis", 64'(misaligned), 64'd1);
    check_eq("plan_mis_tpc", trap_pc, 64'd6);
    check_eq("plan_mis_pc", endereco, 64'h100);
    check_eq("plan_mis_vld", 64'(fetch_valid), 64'd0);
    cycle("trap_br_ignored", 0, 1, 0, 0, 0, '0, 64'd40, 1'b1, 0);
    cycle("ack", 0, 0, 0, 0, 0, '0, '0, 1'b1, 1);
    check_eq("plan_resume_vld", 64'(fetch_valid), 64'd1);
    check_eq("plan_resume_pc", endereco, 64'h100);
    idle("resume", 1'b1);

    // Stall freezes everything, then sequential progress
    for (int i = 0; i < 3; i++) cycle("stall", 1, 1, 0, 0, 0, '0, 64'd16, 1'b1, 0);
    check_eq("plan_stall_pc", endereco, 64'h104);
    idle("post_stall", 1'b1);
    check_eq("plan_post_stall", endereco, 64'h108);

    // auipc next_pc and wrap-around
    do_reset();
    idle("boot", 1'b1);
    cycle("jalr_top", 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, '0, 1'b1, 0);
    stall = 0; branch = 0; jal = 0; jalr = 0; auipc = 1; imm = 64'd1; fetch_ready = 0;
    #1;
    check_eq("plan_auipc", next_pc, 64'hFFC);
    cycle("auipc", 0, 0, 0, 0, 1, '0, 64'd1, 1'b0, 0);
    idle("wrap", 1'b1);
    check_eq("plan_wrap", endereco, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      k = int'($urandom_range(0, 64)) - 32;
      r_imm = XLEN'(k * 4);
      if ($urandom_range(0, 7) == 0) r_imm = r_imm + XLEN'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) r_imm = {$urandom, $urandom};
      r_tp = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_tp[1:0] = 2'b00;
      cycle("rnd",
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0,
            r_tp, r_imm,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
